// File: rtl/intc_irq_ctrl_pkg.sv
// Purpose: shared constants, register decode type and address decoder for the interrupt controller.
// Latency: none, declarations only.
// Backpressure: not applicable.
package intc_irq_ctrl_pkg;

  localparam int unsigned INTC_VEC_W  = 6;
  localparam int unsigned INTC_ADDR_W = 5;
  localparam int unsigned INTC_DATA_W = 32;

  localparam logic [INTC_ADDR_W-1:0] INTC_ADDR_RAW    = 5'h00;
  localparam logic [INTC_ADDR_W-1:0] INTC_ADDR_PEND   = 5'h04;
  localparam logic [INTC_ADDR_W-1:0] INTC_ADDR_ENABLE = 5'h08;
  localparam logic [INTC_ADDR_W-1:0] INTC_ADDR_MODE   = 5'h0C;
  localparam logic [INTC_ADDR_W-1:0] INTC_ADDR_POL    = 5'h10;
  localparam logic [INTC_ADDR_W-1:0] INTC_ADDR_SWSET  = 5'h14;

  typedef enum logic [2:0] {
    REG_RAW    = 3'd0,
    REG_PEND   = 3'd1,
    REG_ENABLE = 3'd2,
    REG_MODE   = 3'd3,
    REG_POL    = 3'd4,
    REG_SWSET  = 3'd5,
    REG_NONE   = 3'd7
  } intc_reg_e;

  // Caller passes a word-aligned offset; unmapped offsets decode to REG_NONE.
  function automatic intc_reg_e intc_decode(input logic [INTC_ADDR_W-1:0] addr);
    case (addr)
      INTC_ADDR_RAW:    return REG_RAW;
      INTC_ADDR_PEND:   return REG_PEND;
      INTC_ADDR_ENABLE: return REG_ENABLE;
      INTC_ADDR_MODE:   return REG_MODE;
      INTC_ADDR_POL:    return REG_POL;
      INTC_ADDR_SWSET:  return REG_SWSET;
      default:          return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/intc_irq_ctrl_sync_edge.sv
// Purpose: per-source synchroniser, polarity correction and rising-edge detector with reloadable history.
// Latency: o_act follows i_line after SYNC_STAGES edges; o_rise is combinational from o_act and history.
// Backpressure: none, free-running every cycle.
module intc_irq_ctrl_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_line,
  input  logic i_pol,
  input  logic i_reload,
  input  logic i_reload_pol,
  output logic o_act,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // shift the asynchronous line through the synchroniser chain
  always_ff @(posedge clk) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], i_line};
  end

  // Edge history; on a MODE/POL change it is loaded with the act value the next cycle will see,
  // so the configuration change itself cannot look like an edge.
  always_ff @(posedge clk) begin
    if (rst)           r_prev <= 1'b0;
    else if (i_reload) r_prev <= r_sync[SYNC_STAGES-2] ^ i_reload_pol;
    else               r_prev <= o_act;
  end

  assign o_act  = r_sync[SYNC_STAGES-1] ^ i_pol;
  assign o_rise = o_act & ~r_prev;

endmodule

// File: rtl/intc_irq_ctrl.sv
// Purpose: interrupt controller producing the 6-bit CP0 hardware interrupt vector, with a register slave port.
// Latency: line to int_o SYNC_STAGES+2 edges; register writes reach int_o one edge later; ack one cycle after ce.
// Backpressure: none, accepts a bus access every cycle and always acknowledges the next cycle.
module intc_irq_ctrl #(
  parameter int NUM_SRC     = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_i,
  input  logic               bus_ce_i,
  input  logic               bus_we_i,
  input  logic [4:0]         bus_addr_i,
  input  logic [31:0]        bus_wdata_i,
  output logic [31:0]        bus_rdata_o,
  output logic               bus_ack_o,
  output logic [5:0]         int_o
);
  import intc_irq_ctrl_pkg::*;

  logic [NUM_SRC-1:0] r_pend, r_enable, r_mode, r_pol;
  logic [5:0]         r_int;
  logic               r_ack;
  logic [31:0]        r_rdata;

  logic [NUM_SRC-1:0] w_act, w_rise, w_wdat, w_w1c, w_swset;
  logic [NUM_SRC-1:0] w_mode_next, w_pol_next, w_reload, w_pend_next;
  logic [31:0]        w_rdat;
  logic [5:0]         w_int_vec;
  logic               w_wr;
  intc_reg_e          w_reg;
  logic               w_unused;

  assign w_reg    = intc_decode({bus_addr_i[4:2], 2'b00});
  assign w_wr     = bus_ce_i & bus_we_i;
  assign w_wdat   = bus_wdata_i[NUM_SRC-1:0];
  assign w_unused = ^{bus_addr_i[1:0], bus_wdata_i};

  assign w_w1c       = (w_wr && w_reg == REG_PEND)  ? w_wdat : '0;
  assign w_swset     = (w_wr && w_reg == REG_SWSET) ? w_wdat : '0;
  assign w_mode_next = (w_wr && w_reg == REG_MODE)  ? w_wdat : r_mode;
  assign w_pol_next  = (w_wr && w_reg == REG_POL)   ? w_wdat : r_pol;
  assign w_reload    = (w_mode_next ^ r_mode) | (w_pol_next ^ r_pol);

  genvar g;
  generate
    for (g = 0; g < NUM_SRC; g++) begin : g_src
      intc_irq_ctrl_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
      ) u_sync_edge (
        .clk          (clk),
        .rst          (rst),
        .i_line       (irq_i[g]),
        .i_pol        (r_pol[g]),
        .i_reload     (w_reload[g]),
        .i_reload_pol (w_pol_next[g]),
        .o_act        (w_act[g]),
        .o_rise       (w_rise[g])
      );
    end
  endgenerate

  // Edge sources latch (set beats W1C); level sources track act; a MODE/POL change clears the bit.
  always_comb begin
    w_pend_next = (r_mode & ((r_pend & ~w_w1c) | w_rise | w_swset)) | (~r_mode & w_act);
    w_pend_next = w_pend_next & ~w_reload;
  end

  // read mux returns register contents as they stand before the access edge
  always_comb begin
    w_rdat = '0;
    case (w_reg)
      REG_RAW:    w_rdat[NUM_SRC-1:0] = w_act;
      REG_PEND:   w_rdat[NUM_SRC-1:0] = r_pend;
      REG_ENABLE: w_rdat[NUM_SRC-1:0] = r_enable;
      REG_MODE:   w_rdat[NUM_SRC-1:0] = r_mode;
      REG_POL:    w_rdat[NUM_SRC-1:0] = r_pol;
      default:    w_rdat = '0;
    endcase
  end

  // widen the masked pending vector to the fixed 6-bit CP0 interface, unused bits tied low
  always_comb begin
    w_int_vec = '0;
    w_int_vec[NUM_SRC-1:0] = r_pend & r_enable;
  end

  // register file, pending state, interrupt vector and bus response
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend   <= '0;
      r_enable <= '0;
      r_mode   <= '0;
      r_pol    <= '0;
      r_int    <= '0;
      r_ack    <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_pend <= w_pend_next;
      r_mode <= w_mode_next;
      r_pol  <= w_pol_next;
      if (w_wr && w_reg == REG_ENABLE) r_enable <= w_wdat;
      r_int  <= w_int_vec;
      r_ack  <= bus_ce_i;
      r_rdata <= (bus_ce_i && !bus_we_i) ? w_rdat : '0;
    end
  end

  assign bus_ack_o   = r_ack;
  assign bus_rdata_o = r_rdata;
  assign int_o       = r_int;

endmodule

// File: tb/tb_intc_irq_ctrl.sv
// Purpose: directed self-checking bench for intc_irq_ctrl with hand-computed expectations.
// Latency: inputs driven on negedge, outputs sampled on negedge, half a cycle after the active edge.
// Backpressure: not applicable.
module tb_intc_irq_ctrl;

  localparam logic [4:0] A_RAW    = 5'h00;
  localparam logic [4:0] A_PEND   = 5'h04;
  localparam logic [4:0] A_ENABLE = 5'h08;
  localparam logic [4:0] A_MODE   = 5'h0C;
  localparam logic [4:0] A_POL    = 5'h10;
  localparam logic [4:0] A_SWSET  = 5'h14;
  localparam logic [4:0] A_HOLE   = 5'h1C;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  irq;
  logic        bus_ce, bus_we;
  logic [4:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic [5:0]  int_vec;

  int n_checks = 0;
  int n_fail   = 0;

  intc_irq_ctrl #(
    .NUM_SRC     (6),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .irq_i       (irq),
    .bus_ce_i    (bus_ce),
    .bus_we_i    (bus_we),
    .bus_addr_i  (bus_addr),
    .bus_wdata_i (bus_wdata),
    .bus_rdata_o (bus_rdata),
    .bus_ack_o   (bus_ack),
    .int_o       (int_vec)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic bus_rd(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    bus_ce = 1'b1; bus_we = 1'b0; bus_addr = a; bus_wdata = 32'h0;
    @(negedge clk);
    bus_ce = 1'b0;
    n_checks++;
    if (bus_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL rd_ack addr=%h got %b expected 1", a, bus_ack);
    end
    d = bus_rdata;
  endtask

  task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_ce = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
    @(negedge clk);
    bus_ce = 1'b0; bus_we = 1'b0;
    n_checks++;
    if (bus_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_ack addr=%h got %b expected 1", a, bus_ack);
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic [4:0]  offs [6];
    offs = '{A_RAW, A_PEND, A_ENABLE, A_MODE, A_POL, A_SWSET};
    rst = 1'b1; irq = '0;
    bus_ce = 1'b1; bus_we = 1'b0; bus_addr = A_ENABLE; bus_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus_ack !== 1'b0) begin
      n_fail++; $display("FAIL reset_no_ack got %b expected 0", bus_ack);
    end
    rst = 1'b0; bus_ce = 1'b0;
    @(negedge clk);
    n_checks++;
    if (int_vec !== 6'h00) begin
      n_fail++; $display("FAIL reset_int got %h expected 00", int_vec);
    end
    n_checks++;
    if (bus_ack !== 1'b0 || bus_rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_idle ack=%b rdata=%h expected 0/0", bus_ack, bus_rdata);
    end
    for (int i = 0; i < 6; i++) begin
      bus_rd(offs[i], rd);
      n_checks++;
      if (rd !== 32'h0) begin
        n_fail++; $display("FAIL reset_read addr=%h got %h expected 00000000", offs[i], rd);
      end
    end
    @(negedge clk);
    n_checks++;
    if (bus_ack !== 1'b0 || bus_rdata !== 32'h0) begin
      n_fail++; $display("FAIL ack_one_cycle ack=%b rdata=%h expected 0/0", bus_ack, bus_rdata);
    end
  endtask

  task automatic test_level();
    bus_wr(A_ENABLE, 32'h3F);
    @(negedge clk); irq[2] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (int_vec !== 6'h00) begin
      n_fail++; $display("FAIL level_early got %h expected 00", int_vec);
    end
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (int_vec !== 6'h04) begin
      n_fail++; $display("FAIL level_rise got %h expected 04", int_vec);
    end
    irq[2] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (int_vec !== 6'h04) begin
      n_fail++; $display("FAIL level_hold got %h expected 04", int_vec);
    end
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (int_vec !== 6'h00) begin
      n_fail++; $display("FAIL level_fall got %h expected 00", int_vec);
    end
  endtask

  task automatic test_edge_latch();
    logic [31:0] rd;
    bus_wr(A_MODE, 32'h01);
    bus_wr(A_ENABLE, 32'h01);
    @(negedge clk); irq[0] = 1'b1;
    @(negedge clk); irq[0] = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (int_vec !== 6'h01) begin
      n_fail++; $display("FAIL edge_int got %h expected 01", int_vec);
    end
    bus_rd(A_PEND, rd);
    n_checks++;
    if (rd !== 32'h1) begin
      n_fail++; $display("FAIL edge_pend got %h expected 00000001", rd);
    end
    bus_wr(A_PEND, 32'h1);
    n_checks++;
    if (int_vec !== 6'h01) begin
      n_fail++; $display("FAIL w1c_same_edge got %h expected 01", int_vec);
    end
    @(negedge clk);
    n_checks++;
    if (int_vec !== 6'h00) begin
      n_fail++; $display("FAIL w1c_int got %h expected 00", int_vec);
    end
    bus_rd(A_PEND, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++; $display("FAIL w1c_pend got %h expected 00000000", rd);
    end
  endtask

  task automatic test_set_wins();
    logic [31:0] rd;
    @(negedge clk); irq[0] = 1'b1;
    @(posedge clk); @(posedge clk);
    bus_wr(A_PEND, 32'h1);
    bus_rd(A_PEND, rd);
    n_checks++;
    if (rd !== 32'h1) begin
      n_fail++; $display("FAIL set_wins_pend got %h expected 00000001", rd);
    end
    n_checks++;
    if (int_vec !== 6'h01) begin
      n_fail++; $display("FAIL set_wins_int got %h expected 01", int_vec);
    end
    bus_wr(A_PEND, 32'h1);
    repeat (4) @(negedge clk);
    bus_rd(A_PEND, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++; $display("FAIL held_no_reset got %h expected 00000000", rd);
    end
    irq[0] = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_pol_change();
    logic [31:0] rd;
    bus_wr(A_MODE, 32'h09);
    bus_wr(A_POL, 32'h08);
    repeat (4) @(negedge clk);
    bus_rd(A_PEND, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++; $display("FAIL pol_no_edge got %h expected 00000000", rd);
    end
    bus_rd(A_RAW, rd);
    n_checks++;
    if (rd !== 32'h08) begin
      n_fail++; $display("FAIL pol_raw got %h expected 00000008", rd);
    end
  endtask

  task automatic test_swset();
    logic [31:0] rd;
    bus_wr(A_POL, 32'h0);
    bus_wr(A_MODE, 32'h10);
    bus_wr(A_ENABLE, 32'h3F);
    bus_wr(A_SWSET, 32'h30);
    bus_rd(A_PEND, rd);
    n_checks++;
    if (rd !== 32'h10) begin
      n_fail++; $display("FAIL swset_pend got %h expected 00000010", rd);
    end
    n_checks++;
    if (int_vec !== 6'h10) begin
      n_fail++; $display("FAIL swset_int got %h expected 10", int_vec);
    end
    bus_rd(A_SWSET, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++; $display("FAIL swset_read got %h expected 00000000", rd);
    end
    bus_wr(A_HOLE, 32'hFFFF_FFFF);
    bus_rd(A_HOLE, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++; $display("FAIL hole_read got %h expected 00000000", rd);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus_ce = 1'b1; bus_we = 1'b1; bus_addr = A_ENABLE; bus_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    n_checks++;
    if (bus_ack !== 1'b1) begin
      n_fail++; $display("FAIL b2b_wr_ack got %b expected 1", bus_ack);
    end
    bus_we = 1'b0; bus_addr = A_ENABLE; bus_wdata = 32'h0;
    @(negedge clk);
    n_checks++;
    if (bus_ack !== 1'b1 || bus_rdata !== 32'h3F) begin
      n_fail++; $display("FAIL b2b_enable ack=%b rdata=%h expected 1/0000003f", bus_ack, bus_rdata);
    end
    bus_addr = A_MODE;
    @(negedge clk);
    n_checks++;
    if (bus_ack !== 1'b1 || bus_rdata !== 32'h10) begin
      n_fail++; $display("FAIL b2b_mode ack=%b rdata=%h expected 1/00000010", bus_ack, bus_rdata);
    end
    bus_addr = A_PEND;
    @(negedge clk);
    n_checks++;
    if (bus_ack !== 1'b1 || bus_rdata !== 32'h10) begin
      n_fail++; $display("FAIL b2b_pend ack=%b rdata=%h expected 1/00000010", bus_ack, bus_rdata);
    end
    bus_ce = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus_ack !== 1'b0 || bus_rdata !== 32'h0) begin
      n_fail++; $display("FAIL b2b_idle ack=%b rdata=%h expected 0/00000000", bus_ack, bus_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_level();
    test_edge_latch();
    test_set_wins();
    test_pol_change();
    test_swset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
